// File: rtl/prog_pkg.sv
// Shared definitions for the program sequencer and the program memory it addresses.
package prog_pkg;

   localparam int PSIZE = 5;
   localparam int SSIZE = 4;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HALT  = 2'd1,
      FAULT = 2'd2
   } seq_state_t;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses. The caller guarantees push only when not full and pop only when not empty.
module return_stack #(
   parameter  int Psize = 5,
   parameter  int Ssize = 4,
   localparam int SPW   = $clog2(Ssize + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [Psize-1:0] din,
   output logic [Psize-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [SPW-1:0]   count
);

   localparam int IW = (Ssize > 1) ? $clog2(Ssize) : 1;

   logic [Psize-1:0] mem [Ssize];
   logic [SPW-1:0]   sp_q;
   logic [SPW-1:0]   sp_m1;
   logic [IW-1:0]    wr_idx;
   logic [IW-1:0]    rd_idx;

   assign sp_m1  = sp_q - SPW'(1);
   assign wr_idx = sp_q[IW-1:0];
   assign rd_idx = sp_m1[IW-1:0];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sp_q <= '0;
      end else if (push) begin
         sp_q <= sp_q + SPW'(1);
      end else if (pop) begin
         sp_q <= sp_m1;
      end
   end

   // Entry contents are don't-care after reset, so storage carries no reset.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_idx] <= din;
      end
   end

   assign dout  = mem[rd_idx];
   assign full  = (sp_q == SPW'(Ssize));
   assign empty = (sp_q == '0);
   assign count = sp_q;

endmodule

// File: rtl/prog_sequencer.sv
// Program counter and return-stack controller driving the program memory address.
// Commands are sampled on the rising edge; only the highest-priority one acts.
module prog_sequencer
   import prog_pkg::*;
#(
   parameter  int Psize = PSIZE,
   parameter  int Ssize = SSIZE,
   localparam int SPW   = $clog2(Ssize + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             branch,
   input  logic             call,
   input  logic             ret,
   input  logic             halt,
   input  logic             resume,
   input  logic [Psize-1:0] target,
   output logic [Psize-1:0] address,
   output logic             running,
   output logic             overflow,
   output logic             underflow,
   output seq_state_t       state,
   output logic [SPW-1:0]   sp
);

   seq_state_t       next_state;
   logic [Psize-1:0] pc;
   logic [Psize-1:0] next_pc;
   logic [Psize-1:0] pc_inc;
   logic [Psize-1:0] stk_dout;
   logic             stk_full;
   logic             stk_empty;
   logic             push;
   logic             pop;
   logic             set_ovf;
   logic             set_unf;

   assign pc_inc = pc + Psize'(1);

   return_stack #(
      .Psize (Psize),
      .Ssize (Ssize)
   ) u_stack (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .dout  (stk_dout),
      .full  (stk_full),
      .empty (stk_empty),
      .count (sp)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         pc        <= '0;
         running   <= 1'b1;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         state     <= next_state;
         pc        <= next_pc;
         running   <= (next_state == RUN);
         overflow  <= overflow | set_ovf;
         underflow <= underflow | set_unf;
      end
   end

   always_comb begin
      next_state = state;
      next_pc    = pc;
      push       = 1'b0;
      pop        = 1'b0;
      set_ovf    = 1'b0;
      set_unf    = 1'b0;
      unique case (state)
         RUN: begin
            if (halt) begin
               next_state = HALT;
            end else if (ret) begin
               if (stk_empty) begin
                  set_unf    = 1'b1;
                  next_state = FAULT;
               end else begin
                  pop     = 1'b1;
                  next_pc = stk_dout;
               end
            end else if (call) begin
               // A full stack faults before anything is pushed or loaded.
               if (stk_full) begin
                  set_ovf    = 1'b1;
                  next_state = FAULT;
               end else begin
                  push    = 1'b1;
                  next_pc = target;
               end
            end else if (branch) begin
               next_pc = target;
            end else if (inc) begin
               next_pc = pc_inc;
            end
         end
         HALT: begin
            if (resume) begin
               next_state = RUN;
            end
         end
         FAULT: begin
            next_state = FAULT;
         end
         default: begin
            next_state = FAULT;
         end
      endcase
   end

   assign address = pc;

endmodule
